nn_layer_sequencer: RTL and testbench

- Top-level scheduler for the layered inference datapath. On a start edge it walks layers 0..NUM_LAYERS-1 in order.
- For each layer it issues a load_start pulse and waits for load_done, then issues a comp_start pulse and waits for comp_done.
- layer_idx steers the external per-layer start/done muxing between the weight loaders (weight_loader_layer*) and the MAC units.
- It also reports busy, done, timeout error and a saturating run-cycle count.

---
 rtl/nn_layer_sequencer.sv | 137 +++++++++++++
 tb/tb_nn_layer_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_sequencer.sv
// Layer scheduler: for each layer, pulse load_start and wait for load_done, then
// pulse comp_start and wait for comp_done. Reports busy/done/error and run length.
module nn_layer_sequencer #(
  parameter int NUM_LAYERS     = 2,
  parameter int LIDX_W         = 2,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_W           = 10,
  parameter int CYC_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              load_start,
  input  logic              load_done,
  output logic              comp_start,
  input  logic              comp_done,
  output logic [LIDX_W-1:0] layer_idx,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CYC_W-1:0]  run_cycles
);

  typedef enum logic [2:0] {
    IDLE, LOAD_REQ, LOAD_WAIT, COMP_REQ, COMP_WAIT, ERROR
  } state_t;

  localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LIDX_W-1:0] LAST_LAYER = LIDX_W'(NUM_LAYERS - 1);

  state_t              state_reg, state_next;
  logic [TO_W-1:0]     to_cnt_reg, to_cnt_next;
  logic [LIDX_W-1:0]   layer_reg, layer_next;
  logic                done_reg, done_next;
  logic [CYC_W-1:0]    cyc_reg, cyc_next;
  logic                start_q, load_done_q, comp_done_q;
  logic                start_rise, load_rise, comp_rise;
  logic                busy_int, timed_out;

  assign start_rise = start & ~start_q;
  assign load_rise  = load_done & ~load_done_q;
  assign comp_rise  = comp_done & ~comp_done_q;

  assign busy_int  = (state_reg == LOAD_REQ) || (state_reg == LOAD_WAIT) ||
                     (state_reg == COMP_REQ) || (state_reg == COMP_WAIT);
  assign timed_out = (to_cnt_reg == TO_LAST);

  always_comb begin
    state_next  = state_reg;
    to_cnt_next = to_cnt_reg;
    layer_next  = layer_reg;
    done_next   = done_reg;
    cyc_next    = cyc_reg;

    if (busy_int && (cyc_reg != '1))
      cyc_next = cyc_reg + 1'b1;

    // abort outranks every done edge and timeout in the active states
    if (busy_int && abort) begin
      state_next = IDLE;
      layer_next = '0;
      done_next  = 1'b0;
    end else begin
      case (state_reg)
        IDLE, ERROR: begin
          if (start_rise) begin
            state_next = LOAD_REQ;
            layer_next = '0;
            done_next  = 1'b0;
            cyc_next   = '0;
          end
        end
        LOAD_REQ: begin
          state_next  = LOAD_WAIT;
          to_cnt_next = '0;
        end
        LOAD_WAIT: begin
          if (load_rise)      state_next  = COMP_REQ;
          else if (timed_out) state_next  = ERROR;
          else                to_cnt_next = to_cnt_reg + 1'b1;
        end
        COMP_REQ: begin
          state_next  = COMP_WAIT;
          to_cnt_next = '0;
        end
        COMP_WAIT: begin
          if (comp_rise) begin
            if (layer_reg == LAST_LAYER) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              state_next = LOAD_REQ;
              layer_next = layer_reg + 1'b1;
            end
          end else if (timed_out) begin
            state_next = ERROR;
          end else begin
            to_cnt_next = to_cnt_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      to_cnt_reg  <= '0;
      layer_reg   <= '0;
      done_reg    <= 1'b0;
      cyc_reg     <= '0;
      start_q     <= 1'b0;
      load_done_q <= 1'b0;
      comp_done_q <= 1'b0;
    end else begin
      state_reg   <= state_next;
      to_cnt_reg  <= to_cnt_next;
      layer_reg   <= layer_next;
      done_reg    <= done_next;
      cyc_reg     <= cyc_next;
      start_q     <= start;
      load_done_q <= load_done;
      comp_done_q <= comp_done;
    end
  end

  assign load_start = (state_reg == LOAD_REQ);
  assign comp_start = (state_reg == COMP_REQ);
  assign layer_idx  = layer_reg;
  assign busy       = busy_int;
  assign done       = done_reg;
  assign error      = (state_reg == ERROR);
  assign run_cycles = cyc_reg;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Self-checking bench: expected load/comp pulses are queued when a run is started
// and popped by a monitor as the sequencer emits them; scenario tasks check status.
module tb_nn_layer_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic load_done = 1'b0, comp_done = 1'b0;
  logic load_start, comp_start, busy, done, error;
  logic [1:0]  layer_idx;
  logic [15:0] run_cycles;
  logic s_load_start, s_comp_start, s_busy, s_done, s_error;
  logic [1:0] s_layer_idx;
  logic [2:0] s_run_cycles;

  always #5 clk = ~clk;

  nn_layer_sequencer #(.NUM_LAYERS(2), .LIDX_W(2), .TIMEOUT_CYCLES(16), .TO_W(5), .CYC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .load_start(load_start), .load_done(load_done),
    .comp_start(comp_start), .comp_done(comp_done),
    .layer_idx(layer_idx), .busy(busy), .done(done), .error(error),
    .run_cycles(run_cycles));

  // narrow run counter so saturation is reachable in a short run
  nn_layer_sequencer #(.NUM_LAYERS(2), .LIDX_W(2), .TIMEOUT_CYCLES(16), .TO_W(5), .CYC_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .load_start(s_load_start), .load_done(load_done),
    .comp_start(s_comp_start), .comp_done(comp_done),
    .layer_idx(s_layer_idx), .busy(s_busy), .done(s_done), .error(s_error),
    .run_cycles(s_run_cycles));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed { logic is_comp; logic [1:0] layer; } ev_t;
  ev_t exp_q[$];

  task automatic push_run(input int layers_done, input logic last_comp);
    for (int l = 0; l < layers_done; l++) begin
      exp_q.push_back('{is_comp: 1'b0, layer: 2'(l)});
      if (l < layers_done - 1 || last_comp)
        exp_q.push_back('{is_comp: 1'b1, layer: 2'(l)});
    end
  endtask

  // Monitor: every start pulse must match the head of the expected queue
  logic prev_pulse = 1'b0;
  int last_ls_cyc = 0;
  always @(negedge clk) begin
    if (load_start || comp_start) begin
      ev_t got, e;
      got = '{is_comp: comp_start, layer: layer_idx};
      $display("pulse %s layer=%0d cyc=%0d", comp_start ? "comp" : "load", layer_idx, cyc);
      total++;
      if (load_start && comp_start) begin
        bad++; $display("FAIL pulse_overlap: got both high, want one");
      end
      total++;
      if (prev_pulse) begin
        bad++; $display("FAIL pulse_back_to_back: got pulse in consecutive cycles, want gap");
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL unexpected_pulse: got comp=%0d layer=%0d, want none", got.is_comp, got.layer);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL pulse_order: got comp=%0d layer=%0d want comp=%0d layer=%0d",
                   got.is_comp, got.layer, e.is_comp, e.layer);
        end
      end
      if (load_start) last_ls_cyc = cyc;
    end
    prev_pulse = load_start | comp_start;
  end

  // Responder: raises done inputs dly cycles after the matching start pulse
  bit ld_en = 0, cd_en = 0, level_mode = 0, ld_auto = 0, cd_auto = 0;
  int dly = 3, ld_cnt = 0, cd_cnt = 0;
  always @(negedge clk) begin
    if (!level_mode && ld_auto) begin load_done = 1'b0; ld_auto = 0; end
    if (!level_mode && cd_auto) begin comp_done = 1'b0; cd_auto = 0; end
    if (ld_cnt > 0) begin
      ld_cnt--;
      if (ld_cnt == 0 && ld_en) begin load_done = 1'b1; ld_auto = 1; end
    end
    if (cd_cnt > 0) begin
      cd_cnt--;
      if (cd_cnt == 0 && cd_en) begin comp_done = 1'b1; cd_auto = 1; end
    end
    if (load_start && ld_en) ld_cnt = dly;
    if (comp_start && cd_en) cd_cnt = dly;
  end

  task automatic new_start_edge();
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (load_start !== 1'b0) begin bad++; $display("FAIL rst_load_start: got %0d want 0", load_start); end
    total++; if (comp_start !== 1'b0) begin bad++; $display("FAIL rst_comp_start: got %0d want 0", comp_start); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0d want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %0d want 0", done); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL rst_error: got %0d want 0", error); end
    total++; if (layer_idx !== 2'd0) begin bad++; $display("FAIL rst_layer_idx: got %0d want 0", layer_idx); end
    total++; if (run_cycles !== 16'd0) begin bad++; $display("FAIL rst_run_cycles: got %0d want 0", run_cycles); end
  endtask

  task automatic test_start_held();
    int n = 0;
    dly = 3; ld_en = 1; cd_en = 1;
    push_run(2, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    while (!done && n < 100) begin @(negedge clk); n++; end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL held_done: got %0d want 1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL held_busy: got %0d want 0", busy); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL held_error: got %0d want 0", error); end
    total++; if (run_cycles !== 16'd16) begin bad++; $display("FAIL held_run_cycles: got %0d want 16", run_cycles); end
    total++; if (s_run_cycles !== 3'd7) begin bad++; $display("FAIL held_run_cycles_sat: got %0d want 7", s_run_cycles); end
    repeat (30) @(negedge clk);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL held_missing_pulses: got %0d left want 0", exp_q.size()); end
    total++; if (busy !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL held_rerun: got busy=%0d done=%0d want 0/1", busy, done); end
  endtask

  task automatic test_level_timeout();
    int n = 0;
    ld_en = 1; cd_en = 1; level_mode = 1; dly = 3;
    @(negedge clk); load_done = 1'b0; comp_done = 1'b0;
    push_run(2, 1'b0);
    new_start_edge();
    while (!error && n < 100) begin @(negedge clk); n++; end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL lvl_error: got %0d want 1", error); end
    total++; if (layer_idx !== 2'd1) begin bad++; $display("FAIL lvl_layer_idx: got %0d want 1", layer_idx); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL lvl_status: got busy=%0d done=%0d want 0/0", busy, done); end
    total++; if (cyc - last_ls_cyc != 17) begin bad++; $display("FAIL lvl_timeout_delay: got %0d want 17", cyc - last_ls_cyc); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL lvl_missing_pulses: got %0d left want 0", exp_q.size()); end
    level_mode = 0; ld_en = 0; cd_en = 0;
    @(negedge clk); load_done = 1'b0; comp_done = 1'b0;
  endtask

  task automatic test_no_load_done();
    int n = 0;
    push_run(1, 1'b0);
    new_start_edge();
    @(negedge clk);
    total++; if (error !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL nld_restart: got error=%0d busy=%0d want 0/1", error, busy); end
    total++; if (layer_idx !== 2'd0) begin bad++; $display("FAIL nld_layer_idx: got %0d want 0", layer_idx); end
    while (!error && n < 100) begin @(negedge clk); n++; end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL nld_error: got %0d want 1", error); end
    total++; if (cyc - last_ls_cyc != 17) begin bad++; $display("FAIL nld_timeout_delay: got %0d want 17", cyc - last_ls_cyc); end
    push_run(1, 1'b0);
    new_start_edge();
    @(negedge clk);
    total++; if (error !== 1'b0) begin bad++; $display("FAIL nld_error_clear: got %0d want 0", error); end
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    total++; if (busy !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL nld_abort: got busy=%0d error=%0d want 0/0", busy, error); end
  endtask

  task automatic test_terminal();
    int n = 0;
    exp_q.push_back('{is_comp: 1'b0, layer: 2'd0});
    exp_q.push_back('{is_comp: 1'b1, layer: 2'd0});
    new_start_edge();
    while (!load_start && n < 10) begin @(negedge clk); n++; end
    repeat (16) @(negedge clk);
    load_done = 1'b1;
    @(negedge clk);
    total++; if (comp_start !== 1'b1) begin bad++; $display("FAIL term_comp_start: got %0d want 1", comp_start); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL term_error: got %0d want 0", error); end
    load_done = 1'b0;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL term_abort: got busy=%0d done=%0d want 0/0", busy, done); end
  endtask

  task automatic test_abort();
    int n = 0;
    dly = 3; ld_en = 1; cd_en = 1;
    push_run(2, 1'b1);
    new_start_edge();
    while (!(load_start && layer_idx == 2'd1) && n < 100) begin @(negedge clk); n++; end
    cd_en = 0;
    n = 0;
    while (!comp_start && n < 20) begin @(negedge clk); n++; end
    total++; if (comp_start !== 1'b1) begin bad++; $display("FAIL abort_reach_comp: got %0d want 1", comp_start); end
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      bad++; $display("FAIL abort_status: got busy=%0d done=%0d error=%0d want 0/0/0", busy, done, error); end
    total++; if (layer_idx !== 2'd0) begin bad++; $display("FAIL abort_layer_idx: got %0d want 0", layer_idx); end
    ld_en = 0;
    comp_done = 1'b1;
    @(negedge clk); comp_done = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0 || layer_idx !== 2'd0) begin
      bad++; $display("FAIL abort_late_done: got busy=%0d done=%0d idx=%0d want 0/0/0", busy, done, layer_idx); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL abort_pulses: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_midrun_min_latency();
    int n = 0;
    int t0;
    exp_q.push_back('{is_comp: 1'b0, layer: 2'd0});
    new_start_edge();
    while (!load_start && n < 10) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({load_start, comp_start, busy, done, error} !== 5'b0) begin
      bad++; $display("FAIL midrst_flags: got %b want 00000", {load_start, comp_start, busy, done, error}); end
    total++; if (layer_idx !== 2'd0 || run_cycles !== 16'd0) begin
      bad++; $display("FAIL midrst_values: got idx=%0d cyc=%0d want 0/0", layer_idx, run_cycles); end
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_no_run: got busy=%0d want 0", busy); end
    dly = 1; ld_en = 1; cd_en = 1;
    push_run(2, 1'b1);
    start = 1'b1;
    n = 0;
    while (!load_start && n < 10) begin @(negedge clk); n++; end
    t0 = cyc;
    n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    total++; if (cyc - t0 != 8) begin bad++; $display("FAIL min_latency: got %0d want 8", cyc - t0); end
    total++; if (run_cycles !== 16'd8) begin bad++; $display("FAIL min_run_cycles: got %0d want 8", run_cycles); end
    total++; if (s_run_cycles !== 3'd7) begin bad++; $display("FAIL min_run_cycles_sat: got %0d want 7", s_run_cycles); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL min_pulses: got %0d left want 0", exp_q.size()); end
    ld_en = 0; cd_en = 0;
  endtask

  initial begin
    test_reset();
    test_start_held();
    test_level_timeout();
    test_no_load_done();
    test_terminal();
    test_abort();
    test_reset_midrun_min_latency();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish within 200000 time units, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
